// File: rtl/munoc_master_traffic_gate.sv
// Handshake gate and drain sequencer between the AHB-to-AXI bridge and the
// master NI packetizer. Only valid/ready are touched; payloads bypass this
// block. It limits outstanding reads and writes, holds off W until its AW
// has been seen, and on drain_req blocks new requests, waits for accepted
// traffic to finish, then raises drain_ack as a safe comm_disable point.
module munoc_master_traffic_gate #(
  parameter int MAX_OUTSTANDING_RD = 4,
  parameter int MAX_OUTSTANDING_WR = 4,
  parameter int BW_CNT             = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid_in,
  output logic              ar_ready_out,
  output logic              ar_valid_out,
  input  logic              ar_ready_in,
  input  logic              aw_valid_in,
  output logic              aw_ready_out,
  output logic              aw_valid_out,
  input  logic              aw_ready_in,
  input  logic              w_valid_in,
  input  logic              w_last_in,
  output logic              w_ready_out,
  output logic              w_valid_out,
  input  logic              w_ready_in,
  input  logic              b_valid,
  input  logic              b_ready,
  input  logic              r_valid,
  input  logic              r_ready,
  input  logic              r_last,
  input  logic              drain_req,
  output logic              drain_ack,
  output logic [BW_CNT-1:0] rd_outstanding,
  output logic [BW_CNT-1:0] wr_outstanding,
  output logic              drain_timeout,
  output logic              protocol_error,
  input  logic              err_clear
);

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    DRAINING = 2'd1,
    DRAINED  = 2'd2
  } state_t;

  // Timer wide enough to hold TIMEOUT_CYCLES; a zero limit never fires.
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [BW_CNT-1:0] RD_MAX    = BW_CNT'(MAX_OUTSTANDING_RD);
  localparam logic [BW_CNT-1:0] WR_MAX    = BW_CNT'(MAX_OUTSTANDING_WR);

  state_t            state, state_next;
  logic [BW_CNT-1:0] rd_cnt, wr_cnt, w_pending;
  logic [TMR_W-1:0]  timer;
  logic              allow_ar, allow_aw, allow_w;
  logic              ar_hs, aw_hs, w_hs, wl_hs, b_hs, rl_hs;
  logic [BW_CNT:0]   rd_step, wr_step, wp_step;
  logic              timeout_hit;

  // Up/down step that clamps at zero; MSB flags an attempted underflow.
  // Simultaneous increment and decrement cancel out.
  function automatic logic [BW_CNT:0] cnt_step(input logic [BW_CNT-1:0] cnt,
                                               input logic inc,
                                               input logic dec);
    logic [BW_CNT:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      res = {1'b0, cnt + 1'b1};
    end else if (dec && !inc) begin
      if (cnt == '0) res = {1'b1, cnt};
      else           res = {1'b0, cnt - 1'b1};
    end
    return res;
  endfunction

  assign allow_ar = (state == ACTIVE) && (rd_cnt < RD_MAX);
  assign allow_aw = (state == ACTIVE) && (wr_cnt < WR_MAX);

  assign ar_valid_out = ar_valid_in & allow_ar;
  assign ar_ready_out = ar_ready_in & allow_ar;
  assign aw_valid_out = aw_valid_in & allow_aw;
  assign aw_ready_out = aw_ready_in & allow_aw;

  assign ar_hs = ar_valid_out & ar_ready_in;
  assign aw_hs = aw_valid_out & aw_ready_in;

  // W may only follow an accepted AW, including one accepted this cycle.
  assign allow_w     = (w_pending != '0) | aw_hs;
  assign w_valid_out = w_valid_in & allow_w;
  assign w_ready_out = w_ready_in & allow_w;

  assign w_hs  = w_valid_out & w_ready_in;
  assign wl_hs = w_hs & w_last_in;
  assign b_hs  = b_valid & b_ready;
  assign rl_hs = r_valid & r_ready & r_last;

  assign rd_step = cnt_step(rd_cnt, ar_hs, rl_hs);
  assign wr_step = cnt_step(wr_cnt, aw_hs, b_hs);
  assign wp_step = cnt_step(w_pending, aw_hs, wl_hs);

  // Fires once, on the cycle the drain timer steps onto the limit.
  assign timeout_hit = (state == DRAINING) && (timer < TMR_LIMIT) &&
                       ((timer + 1'b1) == TMR_LIMIT);

  assign drain_ack      = (state == DRAINED);
  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;

  // Outstanding-transaction bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      w_pending <= '0;
    end else begin
      rd_cnt    <= rd_step[BW_CNT-1:0];
      wr_cnt    <= wr_step[BW_CNT-1:0];
      w_pending <= wp_step[BW_CNT-1:0];
    end
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACTIVE;
    else     state <= state_next;
  end

  // Drain sequencing: quiesce decision uses the registered counts.
  always_comb begin
    state_next = state;
    case (state)
      ACTIVE: begin
        if (drain_req) state_next = DRAINING;
      end
      DRAINING: begin
        if (!drain_req) begin
          state_next = ACTIVE;
        end else if ((rd_cnt == '0) && (wr_cnt == '0) && (w_pending == '0)) begin
          state_next = DRAINED;
        end
      end
      DRAINED: begin
        if (!drain_req) state_next = ACTIVE;
      end
      default: state_next = ACTIVE;
    endcase
  end

  // Drain timer: cleared while ACTIVE, saturating count while DRAINING.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state == ACTIVE) begin
      timer <= '0;
    end else if ((state == DRAINING) && (timer < TMR_LIMIT)) begin
      timer <= timer + 1'b1;
    end
  end

  // Sticky error flags; err_clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_timeout  <= 1'b0;
      protocol_error <= 1'b0;
    end else if (err_clear) begin
      drain_timeout  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (timeout_hit)                  drain_timeout  <= 1'b1;
      if (rd_step[BW_CNT] || wr_step[BW_CNT]) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_munoc_master_traffic_gate.sv
// Bench for munoc_master_traffic_gate: directed scenarios followed by random
// traffic, every cycle compared against a transaction-count reference model.
module tb_munoc_master_traffic_gate;

  localparam int MAXR = 4;
  localparam int MAXW = 4;
  localparam int BW   = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ar_valid_in, ar_ready_out, ar_valid_out, ar_ready_in;
  logic          aw_valid_in, aw_ready_out, aw_valid_out, aw_ready_in;
  logic          w_valid_in, w_last_in, w_ready_out, w_valid_out, w_ready_in;
  logic          b_valid, b_ready, r_valid, r_ready, r_last;
  logic          drain_req, drain_ack, drain_timeout, protocol_error, err_clear;
  logic [BW-1:0] rd_outstanding, wr_outstanding;

  munoc_master_traffic_gate #(
    .MAX_OUTSTANDING_RD(MAXR),
    .MAX_OUTSTANDING_WR(MAXW),
    .BW_CNT(BW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .ar_valid_in(ar_valid_in), .ar_ready_out(ar_ready_out),
    .ar_valid_out(ar_valid_out), .ar_ready_in(ar_ready_in),
    .aw_valid_in(aw_valid_in), .aw_ready_out(aw_ready_out),
    .aw_valid_out(aw_valid_out), .aw_ready_in(aw_ready_in),
    .w_valid_in(w_valid_in), .w_last_in(w_last_in), .w_ready_out(w_ready_out),
    .w_valid_out(w_valid_out), .w_ready_in(w_ready_in),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .drain_timeout(drain_timeout), .protocol_error(protocol_error),
    .err_clear(err_clear)
  );

  // Reference model: plain transaction counts and a drain mode
  // (0 = accepting, 1 = draining, 2 = quiesced).
  int m_rd, m_wr, m_wp, m_mode, m_dcyc;
  bit m_tmo, m_perr;
  bit e_arv, e_arr, e_awv, e_awr, e_wv, e_wr;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_wp = 0; m_mode = 0; m_dcyc = 0;
    m_tmo = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_comb();
    bit ok_ar, ok_aw, ok_w, aw_go;
    ok_ar = (m_mode == 0) && (m_rd < MAXR);
    ok_aw = (m_mode == 0) && (m_wr < MAXW);
    e_arv = ar_valid_in && ok_ar;
    e_arr = ar_ready_in && ok_ar;
    e_awv = aw_valid_in && ok_aw;
    e_awr = aw_ready_in && ok_aw;
    aw_go = e_awv && aw_ready_in;
    ok_w  = (m_wp > 0) || aw_go;
    e_wv  = w_valid_in && ok_w;
    e_wr  = w_ready_in && ok_w;
  endtask

  task automatic model_next();
    int ar_n, aw_n, wl_n, b_n, rl_n, nrd, nwr, nwp, nmode;
    bit perr_ev, tmo_ev;
    if (rst) begin
      model_reset();
      return;
    end
    ar_n = (e_arv && ar_ready_in) ? 1 : 0;
    aw_n = (e_awv && aw_ready_in) ? 1 : 0;
    wl_n = (e_wv && w_ready_in && w_last_in) ? 1 : 0;
    b_n  = (b_valid && b_ready) ? 1 : 0;
    rl_n = (r_valid && r_ready && r_last) ? 1 : 0;
    perr_ev = 1'b0;
    tmo_ev  = 1'b0;
    nrd = m_rd + ar_n - rl_n;
    if (nrd < 0) begin nrd = 0; perr_ev = 1'b1; end
    nwr = m_wr + aw_n - b_n;
    if (nwr < 0) begin nwr = 0; perr_ev = 1'b1; end
    nwp = m_wp + aw_n - wl_n;
    if (nwp < 0) nwp = 0;
    case (m_mode)
      0: begin
        m_dcyc = 0;
        nmode  = drain_req ? 1 : 0;
      end
      1: begin
        m_dcyc++;
        tmo_ev = (m_dcyc == TMO);
        if (!drain_req)                              nmode = 0;
        else if (m_rd == 0 && m_wr == 0 && m_wp == 0) nmode = 2;
        else                                         nmode = 1;
      end
      default: nmode = drain_req ? 2 : 0;
    endcase
    if (err_clear) begin
      m_tmo  = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_tmo  = m_tmo | tmo_ev;
      m_perr = m_perr | perr_ev;
    end
    m_rd = nrd; m_wr = nwr; m_wp = nwp; m_mode = nmode;
  endtask

  // One cycle: outputs checked mid-low-phase, model advanced, clock edge taken.
  task automatic tick();
    #1;
    model_comb();
    chk("ar_valid_out", ar_valid_out, e_arv);
    chk("ar_ready_out", ar_ready_out, e_arr);
    chk("aw_valid_out", aw_valid_out, e_awv);
    chk("aw_ready_out", aw_ready_out, e_awr);
    chk("w_valid_out", w_valid_out, e_wv);
    chk("w_ready_out", w_ready_out, e_wr);
    chk("drain_ack", drain_ack, (m_mode == 2));
    chk("rd_outstanding", rd_outstanding, m_rd);
    chk("wr_outstanding", wr_outstanding, m_wr);
    chk("drain_timeout", drain_timeout, m_tmo);
    chk("protocol_error", protocol_error, m_perr);
    n_vec++;
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    ar_valid_in = 0; ar_ready_in = 0; aw_valid_in = 0; aw_ready_in = 0;
    w_valid_in = 0; w_last_in = 0; w_ready_in = 0;
    b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
    err_clear = 0;
  endtask

  initial begin
    bit quiet;
    rst = 1; drain_req = 0;
    idle();
    @(negedge clk);
    model_reset();
    tick();
    rst = 0;
    chk("reset_rd", rd_outstanding, 0);
    chk("reset_ack", drain_ack, 0);
    chk("reset_perr", protocol_error, 0);

    // Read limit: three, fourth, then a held fifth.
    ar_valid_in = 1; ar_ready_in = 1;
    repeat (3) tick();
    chk("rd_after_3", rd_outstanding, 3);
    tick();
    chk("rd_after_4", rd_outstanding, 4);
    chk("ar5_valid_blocked", ar_valid_out, 0);
    chk("ar5_ready_blocked", ar_ready_out, 0);
    tick();
    r_valid = 1; r_ready = 1; r_last = 1;
    tick();
    r_valid = 0; r_ready = 0; r_last = 0;
    chk("ar5_pass_after_r", ar_valid_out, 1);
    tick();
    chk("rd_refill", rd_outstanding, 4);
    ar_valid_in = 0; ar_ready_in = 0;
    r_valid = 1; r_ready = 1; r_last = 1;
    repeat (2) tick();
    ar_valid_in = 1; ar_ready_in = 1;
    tick();
    chk("rd_inc_dec_same", rd_outstanding, 2);
    ar_valid_in = 0; ar_ready_in = 0;
    repeat (2) tick();
    idle();
    chk("rd_empty", rd_outstanding, 0);

    // Write inc+dec in one cycle, then finish both bursts.
    aw_valid_in = 1; aw_ready_in = 1;
    tick();
    b_valid = 1; b_ready = 1;
    tick();
    chk("wr_inc_dec_same", wr_outstanding, 1);
    idle();
    w_valid_in = 1; w_ready_in = 1; w_last_in = 1;
    repeat (2) tick();
    idle();
    b_valid = 1; b_ready = 1;
    tick();
    idle();
    chk("wr_empty", wr_outstanding, 0);

    // Drain with one write in flight.
    aw_valid_in = 1; aw_ready_in = 1;
    tick();
    idle();
    drain_req = 1;
    tick();
    ar_valid_in = 1; ar_ready_in = 1; aw_valid_in = 1; aw_ready_in = 1;
    w_valid_in = 1; w_ready_in = 1; w_last_in = 0;
    #1;
    chk("drain_ar_blocked", ar_valid_out, 0);
    chk("drain_aw_blocked", aw_valid_out, 0);
    chk("drain_w_passes", w_valid_out, 1);
    repeat (3) tick();
    w_last_in = 1;
    tick();
    idle();
    b_valid = 1; b_ready = 1;
    tick();
    idle();
    chk("drain_not_yet_ack", drain_ack, 0);
    tick();
    chk("drain_ack_set", drain_ack, 1);
    drain_req = 0;
    tick();
    chk("drain_ack_release", drain_ack, 0);

    // W ahead of AW is held, W alongside AW passes.
    w_valid_in = 1; w_ready_in = 1; w_last_in = 1;
    #1;
    chk("w_no_aw_valid", w_valid_out, 0);
    chk("w_no_aw_ready", w_ready_out, 0);
    tick();
    aw_valid_in = 1; aw_ready_in = 1;
    #1;
    chk("w_with_aw", w_valid_out, 1);
    tick();
    idle();
    b_valid = 1; b_ready = 1;
    tick();
    idle();
    chk("wr_after_single", wr_outstanding, 0);

    // Drain timeout with one read stuck.
    ar_valid_in = 1; ar_ready_in = 1;
    tick();
    idle();
    drain_req = 1;
    tick();
    repeat (15) tick();
    chk("timeout_not_yet", drain_timeout, 0);
    tick();
    chk("timeout_set", drain_timeout, 1);
    chk("timeout_still_draining", drain_ack, 0);
    r_valid = 1; r_ready = 1; r_last = 1;
    tick();
    idle();
    tick();
    chk("timeout_then_drained", drain_ack, 1);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("timeout_cleared", drain_timeout, 0);
    drain_req = 0;
    tick();

    // Stray B, then reset in the middle of a drain.
    b_valid = 1; b_ready = 1;
    tick();
    idle();
    chk("perr_set", protocol_error, 1);
    chk("perr_wr_zero", wr_outstanding, 0);
    ar_valid_in = 1; ar_ready_in = 1;
    tick();
    idle();
    drain_req = 1;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0; drain_req = 0;
    chk("rst_mid_rd", rd_outstanding, 0);
    chk("rst_mid_perr", protocol_error, 0);
    chk("rst_mid_ack", drain_ack, 0);
    ar_valid_in = 1;
    #1;
    chk("rst_mid_active", ar_valid_out, 1);
    idle();

    // Random traffic; alternate windows withhold responses to provoke timeouts.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      quiet = ((cyc / 250) % 2) == 1;
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      ar_valid_in = ($urandom_range(0, 1) == 1);
      ar_ready_in = ($urandom_range(0, 3) != 0);
      aw_valid_in = ($urandom_range(0, 1) == 1);
      aw_ready_in = ($urandom_range(0, 3) != 0);
      w_valid_in  = ($urandom_range(0, 1) == 1);
      w_ready_in  = ($urandom_range(0, 3) != 0);
      w_last_in   = ($urandom_range(0, 2) == 0);
      r_ready     = ($urandom_range(0, 3) != 0);
      r_last      = ($urandom_range(0, 1) == 1);
      b_ready     = ($urandom_range(0, 3) != 0);
      if (quiet)           r_valid = 0;
      else if (m_rd > 0)   r_valid = ($urandom_range(0, 2) == 0);
      else                 r_valid = ($urandom_range(0, 60) == 0);
      if (quiet)             b_valid = 0;
      else if (m_wr > m_wp)  b_valid = ($urandom_range(0, 2) == 0);
      else if (m_wr == 0)    b_valid = ($urandom_range(0, 60) == 0);
      else                   b_valid = 0;
      err_clear = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
